// File: rtl/color_changer_entry.sv
// ---------------------------------------------------------------------------
// color_changer_entry
//
// Keypad-driven colour entry register. Collects NUM_DIGITS hex digits from a
// 4-bit key code stream and assembles them MSB-first into an RGB colour
// (RRGGBB for the default six digits). It sits between the keypad decoder
// and the display/colour pipeline.
//
// Ports:
//   clk          in   1          system clock, all logic on the rising edge
//   reset        in   1          synchronous, active-low reset
//   value        in   4          current key code; 0 = no key, 1..F = key held
//   final_color  out  4*NUM      assembled colour; digit 0 in the top nibble
//   done         out  1          high once all NUM_DIGITS digits are captured
//
// Handshake: there is no valid/ready pair. A "press" is the only event: it
// happens in any cycle where value is nonzero and differs from the value
// sampled on the previous edge. A held key counts once; a direct change
// between two nonzero codes counts as a new press; 0 never counts.
//
// Optional feature (macro COLOR_CHANGER_REENTRY_EN):
//   defined   - a press while done is high starts a new colour on that edge:
//               final_color = {value, 0...}, count = 1, done = 0.
//   undefined - presses after done are ignored until reset.
// ---------------------------------------------------------------------------
module color_changer_entry #(
    parameter int NUM_DIGITS = 6,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIGIT_W-1:0]            value,
    output logic [DIGIT_W*NUM_DIGITS-1:0] final_color,
    output logic                          done
);

    localparam int COLOR_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [COLOR_W-1:0] final_color_q, final_color_d;
    logic [CNT_W-1:0]   count_q,       count_d;
    logic [DIGIT_W-1:0] prev_value_q;
    logic               done_q,        done_d;

    // -----------------------------------------------------------------------
    // Press detection
    // -----------------------------------------------------------------------
    logic press;
    logic capture;

    assign press   = (value != '0) && (value != prev_value_q);
    // Capturing is only possible while there is still an empty nibble.
    assign capture = press && (count_q < CNT_FULL);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        final_color_d = final_color_q;
        count_d       = count_q;
        done_d        = done_q;

        if (capture) begin
            // Digit i lands in the nibble whose MSB is COLOR_W-1-DIGIT_W*i,
            // so the first key ends up in the top nibble.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (count_q == CNT_W'(i)) begin
                    final_color_d[COLOR_W-1-DIGIT_W*i -: DIGIT_W] = value;
                end
            end
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
                done_d = 1'b1;
            end
        end
`ifdef COLOR_CHANGER_REENTRY_EN
        else if (press && done_q) begin
            // A fresh press after completion starts a new colour, with this
            // key already taken as its first digit.
            final_color_d = {value, {(COLOR_W-DIGIT_W){1'b0}}};
            count_d       = CNT_W'(1);
            done_d        = 1'b0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Registers. Reset wins over every other update, including mid-entry
    // and after done. prev_value clears on reset, so a key held through
    // reset release is seen as a press on the first active cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            final_color_q <= '0;
            count_q       <= '0;
            prev_value_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            final_color_q <= final_color_d;
            count_q       <= count_d;
            prev_value_q  <= value;
            done_q        <= done_d;
        end
    end

    assign final_color = final_color_q;
    assign done        = done_q;

endmodule

// File: tb/tb_color_changer_entry.sv
// ---------------------------------------------------------------------------
// tb_color_changer_entry
//
// Self-checking bench for color_changer_entry. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 time unit after the next
// rising edge. Each scenario pushes the expected {done, final_color} into
// exp_q as it drives a cycle and pops/compares it once that edge has passed.
// Build with +define+COLOR_CHANGER_REENTRY_EN to check the re-entry variant.
// ---------------------------------------------------------------------------
module tb_color_changer_entry;

    localparam int NUM_DIGITS = 6;
    localparam int COLOR_W    = 4 * NUM_DIGITS;
    localparam int EXP_W      = COLOR_W + 1;

    logic               clk;
    logic               reset;
    logic [3:0]         value;
    logic [COLOR_W-1:0] final_color;
    logic               done;

    logic [EXP_W-1:0]   exp_q[$];
    logic [EXP_W-1:0]   got;
    logic [EXP_W-1:0]   want;

    int checks;
    int errors;

    // Reference model state for the random scenario.
    logic [3:0]         m_prev;
    int                 m_cnt;
    logic [COLOR_W-1:0] m_col;
    logic               m_done;

    color_changer_entry #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .final_color (final_color),
        .done        (done)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0]       vals[5]  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        logic             rsts[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [EXP_W-1:0] exps[5]  = '{{1'b0, 24'h000000}, {1'b0, 24'h000000},
                                      {1'b0, 24'h000000}, {1'b0, 24'h100000},
                                      {1'b0, 24'h100000}};
        for (int i = 0; i < 5; i++) begin
            reset = rsts[i];
            value = vals[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    task automatic test_sequence();
        logic [3:0]       vals[9] = '{4'h0, 4'hc, 4'h5, 4'hf, 4'ha, 4'h0, 4'hd, 4'h8, 4'h0};
        logic             rsts[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [EXP_W-1:0] exps[9] = '{{1'b0, 24'h000000}, {1'b0, 24'hc00000},
                                     {1'b0, 24'hc50000}, {1'b0, 24'hc5f000},
                                     {1'b0, 24'hc5fa00}, {1'b0, 24'hc5fa00},
                                     {1'b0, 24'hc5fad0}, {1'b1, 24'hc5fad8},
                                     {1'b1, 24'hc5fad8}};
        for (int i = 0; i < 9; i++) begin
            reset = rsts[i];
            value = vals[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sequence step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    // Runs straight after test_sequence, so the DUT holds c5fad8 / done=1.
    task automatic test_after_done();
        logic [3:0]       vals[3] = '{4'h3, 4'h0, 4'h5};
        logic [EXP_W-1:0] exps[3];
`ifdef COLOR_CHANGER_REENTRY_EN
        exps = '{{1'b0, 24'h300000}, {1'b0, 24'h300000}, {1'b0, 24'h350000}};
`else
        exps = '{{1'b1, 24'hc5fad8}, {1'b1, 24'hc5fad8}, {1'b1, 24'hc5fad8}};
`endif
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            value = vals[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL after_done step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    // A held key counts once; a 4 after "7 7" must land in the third nibble.
    task automatic test_hold();
        logic [3:0]       vals[9] = '{4'h0, 4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h7, 4'h0, 4'h4};
        logic             rsts[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [EXP_W-1:0] exps[9] = '{{1'b0, 24'h000000}, {1'b0, 24'h700000},
                                     {1'b0, 24'h700000}, {1'b0, 24'h700000},
                                     {1'b0, 24'h700000}, {1'b0, 24'h700000},
                                     {1'b0, 24'h770000}, {1'b0, 24'h770000},
                                     {1'b0, 24'h774000}};
        for (int i = 0; i < 9; i++) begin
            reset = rsts[i];
            value = vals[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL hold step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0]       vals[7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 4'h9, 4'h0};
        logic             rsts[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [EXP_W-1:0] exps[7] = '{{1'b0, 24'h000000}, {1'b0, 24'h100000},
                                     {1'b0, 24'h120000}, {1'b0, 24'h123000},
                                     {1'b0, 24'h000000}, {1'b0, 24'h900000},
                                     {1'b0, 24'h900000}};
        for (int i = 0; i < 7; i++) begin
            reset = rsts[i];
            value = vals[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mid_reset step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    // Runs after test_mid_reset: 0 for 10 cycles holds 900000, then a new
    // press proves the count was not disturbed either.
    task automatic test_idle();
        reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            value = (i == 10) ? 4'h2 : 4'h0;
            exp_q.push_back((i == 10) ? {1'b0, 24'h920000} : {1'b0, 24'h900000});
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL idle step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    // Distinct nonzero keys every cycle, no gaps, then one extra key.
    task automatic test_back_to_back();
        logic [3:0]       vals[8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        logic             rsts[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [EXP_W-1:0] exps[8];
        exps[0] = {1'b0, 24'h000000};
        exps[1] = {1'b0, 24'h100000};
        exps[2] = {1'b0, 24'h120000};
        exps[3] = {1'b0, 24'h123000};
        exps[4] = {1'b0, 24'h123400};
        exps[5] = {1'b0, 24'h123450};
        exps[6] = {1'b1, 24'h123456};
`ifdef COLOR_CHANGER_REENTRY_EN
        exps[7] = {1'b0, 24'h700000};
`else
        exps[7] = {1'b1, 24'h123456};
`endif
        for (int i = 0; i < 8; i++) begin
            reset = rsts[i];
            value = vals[i];
            exp_q.push_back(exps[i]);
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    // Behavioural model of one clock edge, used by the random scenario.
    task automatic model_edge(input logic r, input logic [3:0] v);
        logic pressed;
        if (!r) begin
            m_prev = 4'h0;
            m_cnt  = 0;
            m_col  = '0;
            m_done = 1'b0;
        end else begin
            pressed = (v != 4'h0) && (v != m_prev);
            if (pressed && m_cnt < NUM_DIGITS) begin
                m_col[COLOR_W-1-4*m_cnt -: 4] = v;
                m_cnt++;
                if (m_cnt == NUM_DIGITS) m_done = 1'b1;
            end
`ifdef COLOR_CHANGER_REENTRY_EN
            else if (pressed && m_done) begin
                m_col  = {v, 20'h0};
                m_cnt  = 1;
                m_done = 1'b0;
            end
`endif
            m_prev = v;
        end
    endtask

    // Random keys with frequent repeats and zeros, occasional resets.
    task automatic test_random();
        logic       r;
        logic [3:0] v;
        v = 4'h0;
        for (int i = 0; i < 200; i++) begin
            r = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            case ($urandom_range(0, 3))
                0:       v = 4'h0;
                1:       v = v;
                default: v = 4'($urandom_range(0, 15));
            endcase
            reset = r;
            value = v;
            model_edge(r, v);
            exp_q.push_back({m_done, m_col});
            @(posedge clk); #1;
            got  = {done, final_color};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random step %0d: got done=%b color=%h, expected done=%b color=%h",
                         i, got[COLOR_W], got[COLOR_W-1:0], want[COLOR_W], want[COLOR_W-1:0]);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Main sequence and report
    // -----------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        value  = 4'h0;
        m_prev = 4'h0;
        m_cnt  = 0;
        m_col  = '0;
        m_done = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_sequence();
        test_after_done();
        test_hold();
        test_mid_reset();
        test_idle();
        test_back_to_back();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
